// File: rtl/serv_io_mux.sv
// ---------------------------------------------------------------------------
// serv_io_mux
//
// Shares one group of PADS user IO pads between NCORES SERV cores. A small
// Wishbone register bank chooses which core owns the pads and gates each
// core's reset. Every ownership change passes through a guarded handover:
// all pads are tristated for GUARD_CYCLES cycles plus one switch cycle
// before the new owner is connected, so two cores never drive the pads at once.
//
// Optional feature macro: IO_MUX_SYNC_EN
//   defined   : pad_in passes through a 2-flop synchroniser before it is
//               routed to core_in (2 cycles extra input latency)
//   undefined : pad_in is routed combinationally to the active core
//
// Ports
//   wb_clk_i, wb_rst_ni      clock, asynchronous active-low reset
//   wbs_stb_i/cyc_i/we_i     Wishbone strobe, cycle, write enable
//   wbs_sel_i[3:0]           byte selects
//   wbs_adr_i[31:0]          address (block decodes adr[31:4] == ADDR_BASE[31:4])
//   wbs_dat_i[31:0]          write data
//   wbs_ack_o                one-cycle acknowledge
//   wbs_dat_o[31:0]          read data, valid with ack, 0 otherwise
//   pad_in/pad_out/pad_oeb   shared pad group (pad_oeb 1 = tristate)
//   core_out/core_oeb        per-core outputs, core i at [i*PADS +: PADS]
//   core_in                  pad input routed to the owning core
//   core_rst_n[NCORES-1:0]   per-core active-low reset
//
// Register map (adr[3:2])
//   0x0 CTRL    [2:0] sel (r/w), [31] busy (ro)
//   0x4 CORE_EN [NCORES-1:0] (r/w)
//   0x8 STATUS  [15:0] swcount (ro), [18:16] active_sel (ro)
//   0xC         reads 0, writes ignored
// ---------------------------------------------------------------------------
module serv_io_mux #(
   parameter int          NCORES       = 4,
   parameter int          PADS         = 5,
   parameter int          GUARD_CYCLES = 4,
   parameter logic [31:0] ADDR_BASE    = 32'h3000_0000
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_ni,
   input  logic                     wbs_stb_i,
   input  logic                     wbs_cyc_i,
   input  logic                     wbs_we_i,
   input  logic [3:0]               wbs_sel_i,
   input  logic [31:0]              wbs_adr_i,
   input  logic [31:0]              wbs_dat_i,
   output logic                     wbs_ack_o,
   output logic [31:0]              wbs_dat_o,
   input  logic [PADS-1:0]          pad_in,
   output logic [PADS-1:0]          pad_out,
   output logic [PADS-1:0]          pad_oeb,
   input  logic [NCORES*PADS-1:0]   core_out,
   input  logic [NCORES*PADS-1:0]   core_oeb,
   output logic [NCORES*PADS-1:0]   core_in,
   output logic [NCORES-1:0]        core_rst_n
);

   localparam int             GW         = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam logic [GW-1:0]  GUARD_LAST = GW'(GUARD_CYCLES - 1);
   localparam logic [3:0]     NCORES_L   = 4'(NCORES);

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SWITCH = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [GW-1:0]       guard_q, guard_d;
   logic [2:0]          active_sel_q, active_sel_d;
   logic [2:0]          pending_sel_q, pending_sel_d;
   logic [NCORES-1:0]   core_en_q, core_en_d;
   logic [15:0]         swcount_q, swcount_d;
   logic                ack_q, ack_d;
   logic [31:0]         dat_q, dat_d;

   logic                hit;
   logic                access;
   logic                busy;
   logic [31:0]         rd_data;
   logic [PADS-1:0]     pad_route;
   logic                unused_ok;

   assign hit    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
   // An ack is never followed directly by another ack, so each access takes
   // at least two cycles and the master has time to drop its strobe.
   assign access = hit & ~ack_q;
   assign busy   = (state_q != ST_ACTIVE) || (pending_sel_q != active_sel_q);

   assign unused_ok = ^{wbs_sel_i[3:1], wbs_dat_i, wbs_adr_i[1:0]};

   // Register read mux
   always_comb begin
      rd_data = '0;
      case (wbs_adr_i[3:2])
         2'd0:    rd_data = {busy, 28'd0, pending_sel_q};
         2'd1:    rd_data[NCORES-1:0] = core_en_q;
         2'd2:    rd_data = {13'd0, active_sel_q, swcount_q};
         default: rd_data = '0;
      endcase
   end

   // Bus access: writes land on the same edge that raises the ack.
   // Only byte lane 0 carries writable bits (sel and core_en fit in 8 bits).
   always_comb begin
      ack_d         = 1'b0;
      dat_d         = '0;
      pending_sel_d = pending_sel_q;
      core_en_d     = core_en_q;
      if (access) begin
         ack_d = 1'b1;
         if (!wbs_we_i) begin
            dat_d = rd_data;
         end else if (wbs_sel_i[0]) begin
            case (wbs_adr_i[3:2])
               2'd0: begin
                  // Out-of-range selects are acked but dropped
                  if ({1'b0, wbs_dat_i[2:0]} < NCORES_L) begin
                     pending_sel_d = wbs_dat_i[2:0];
                  end
               end
               2'd1:    core_en_d = wbs_dat_i[NCORES-1:0];
               default: ;
            endcase
         end
      end
   end

   // Handover FSM. The new owner is taken from pending_sel only in SWITCH,
   // so writes during DRAIN simply retarget the handover (last write wins).
   // A write landing in SWITCH is caught by ACTIVE on the next cycle.
   always_comb begin
      state_d      = state_q;
      guard_d      = guard_q;
      active_sel_d = active_sel_q;
      swcount_d    = swcount_q;
      case (state_q)
         ST_ACTIVE: begin
            if (pending_sel_q != active_sel_q) begin
               state_d = ST_DRAIN;
               guard_d = '0;
            end
         end
         ST_DRAIN: begin
            if (guard_q == GUARD_LAST) begin
               state_d = ST_SWITCH;
            end else begin
               guard_d = guard_q + 1'b1;
            end
         end
         ST_SWITCH: begin
            active_sel_d = pending_sel_q;
            swcount_d    = swcount_q + 16'd1;
            state_d      = ST_ACTIVE;
         end
         default: state_d = ST_ACTIVE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q       <= ST_ACTIVE;
         guard_q       <= '0;
         active_sel_q  <= '0;
         pending_sel_q <= '0;
         core_en_q     <= '0;
         swcount_q     <= '0;
         ack_q         <= 1'b0;
         dat_q         <= '0;
      end else begin
         state_q       <= state_d;
         guard_q       <= guard_d;
         active_sel_q  <= active_sel_d;
         pending_sel_q <= pending_sel_d;
         core_en_q     <= core_en_d;
         swcount_q     <= swcount_d;
         ack_q         <= ack_d;
         dat_q         <= dat_d;
      end
   end

`ifdef IO_MUX_SYNC_EN
   logic [PADS-1:0] sync1_q, sync2_q;

   // Keeps running in every state so the first sample after a handover is fresh
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= pad_in;
         sync2_q <= sync1_q;
      end
   end

   assign pad_route = sync2_q;
`else
   assign pad_route = pad_in;
`endif

   // Pad routing. The combinational path is also qualified by wb_rst_ni so
   // the pads and core inputs go quiet the moment reset is asserted, not
   // only once the state flops have settled back to ACTIVE/sel 0.
   always_comb begin
      pad_out = '0;
      pad_oeb = '1;
      core_in = '0;
      if (wb_rst_ni && (state_q == ST_ACTIVE)) begin
         for (int i = 0; i < NCORES; i++) begin
            if (active_sel_q == 3'(i)) begin
               pad_out                 = core_out[i*PADS +: PADS];
               pad_oeb                 = core_oeb[i*PADS +: PADS] | {PADS{~core_en_q[i]}};
               core_in[i*PADS +: PADS] = pad_route;
            end
         end
      end
   end

   assign wbs_ack_o  = ack_q;
   assign wbs_dat_o  = dat_q;
   assign core_rst_n = core_en_q;

endmodule

// File: tb/tb_serv_io_mux.sv
// ---------------------------------------------------------------------------
// tb_serv_io_mux
//
// Directed bench for serv_io_mux with default parameters (4 cores, 5 pads,
// 4 guard cycles). Drives Wishbone accesses and pad/core traffic, and checks
// register contents, pad routing, handover timing, boundary writes and
// asynchronous reset against hand-computed values.
// ---------------------------------------------------------------------------
module tb_serv_io_mux;

   localparam int NCORES = 4;
   localparam int PADS   = 5;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic                   clk;
   logic                   rst_n;
   logic                   stb, cyc, we;
   logic [3:0]             sel;
   logic [31:0]            adr, wdat;
   logic                   wbs_ack_o;
   logic [31:0]            wbs_dat_o;
   logic [PADS-1:0]        pad_in;
   logic [PADS-1:0]        pad_out;
   logic [PADS-1:0]        pad_oeb;
   logic [NCORES*PADS-1:0] core_out;
   logic [NCORES*PADS-1:0] core_oeb;
   logic [NCORES*PADS-1:0] core_in;
   logic [NCORES-1:0]      core_rst_n;

   int testsRun;
   int testsFailed;
   int triCount;

   serv_io_mux #(
      .NCORES       (NCORES),
      .PADS         (PADS),
      .GUARD_CYCLES (4),
      .ADDR_BASE    (BASE)
   ) dut (
      .wb_clk_i   (clk),
      .wb_rst_ni  (rst_n),
      .wbs_stb_i  (stb),
      .wbs_cyc_i  (cyc),
      .wbs_we_i   (we),
      .wbs_sel_i  (sel),
      .wbs_adr_i  (adr),
      .wbs_dat_i  (wdat),
      .wbs_ack_o  (wbs_ack_o),
      .wbs_dat_o  (wbs_dat_o),
      .pad_in     (pad_in),
      .pad_out    (pad_out),
      .pad_oeb    (pad_oeb),
      .core_out   (core_out),
      .core_oeb   (core_oeb),
      .core_in    (core_in),
      .core_rst_n (core_rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it, and on mismatch counts and reports it
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // One Wishbone access with a bounded wait for the ack
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                input logic w, input logic [3:0] s,
                                output logic [31:0] rdata, output logic acked);
      @(negedge clk);
      adr = a; wdat = d; we = w; sel = s; stb = 1'b1; cyc = 1'b1;
      acked = 1'b0;
      rdata = '0;
      for (int i = 0; i < 8 && !acked; i++) begin
         @(posedge clk);
         #1;
         if (wbs_ack_o) begin
            acked = 1'b1;
            rdata = wbs_dat_o;
         end
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
   endtask

   task automatic busWrite(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      logic [31:0] rd;
      logic        ok;
      applyStimulus(a, d, 1'b1, s, rd, ok);
      checkOutput({tag, "_ack"}, 32'(ok), 32'd1);
   endtask

   task automatic busRead(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      logic        ok;
      applyStimulus(a, 32'd0, 1'b0, 4'hF, rd, ok);
      checkOutput({tag, "_ack"}, 32'(ok), 32'd1);
      checkOutput(tag, rd, exp);
   endtask

   initial begin
      logic [31:0] rd;
      logic        ok;
      testsRun    = 0;
      testsFailed = 0;
      stb = 0; cyc = 0; we = 0; sel = 4'h0; adr = '0; wdat = '0;
      pad_in   = '0;
      core_out = {5'h13, 5'h0A, 5'h0C, 5'h15};
      core_oeb = {5'b00011, 5'b00000, 5'b00000, 5'b00000};
      rst_n    = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_pad_oeb",    32'(pad_oeb),    32'h1F);
      checkOutput("rst_pad_out",    32'(pad_out),    32'h00);
      checkOutput("rst_core_in",    32'(core_in),    32'h0);
      checkOutput("rst_core_rst_n", 32'(core_rst_n), 32'h0);
      checkOutput("rst_ack",        32'(wbs_ack_o),  32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      busRead("rd_ctrl0",   BASE + 32'h0, 32'h0);
      busRead("rd_coreen0", BASE + 32'h4, 32'h0);
      busRead("rd_status0", BASE + 32'h8, 32'h0);
      checkOutput("idle_dat_zero", wbs_dat_o, 32'h0);
      checkOutput("idle_pad_oeb",  32'(pad_oeb), 32'h1F);

      // Enable all cores; core 0 owns the pads
      busWrite("wr_coreen_f", BASE + 32'h4, 32'hF, 4'hF);
      checkOutput("en_core_rst_n", 32'(core_rst_n), 32'hF);
      checkOutput("en_pad_out",    32'(pad_out),    32'h15);
      checkOutput("en_pad_oeb",    32'(pad_oeb),    32'h00);
      busRead("rd_coreen_f", BASE + 32'h4, 32'hF);
      pad_in = 5'h0A;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("core_in_c0", 32'(core_in), 32'h0000A);

      // Handover 0 -> 2: pads tristated for GUARD_CYCLES+1 cycles
      busWrite("wr_ctrl_2", BASE + 32'h0, 32'h2, 4'hF);
      triCount = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (pad_oeb == 5'h1F) triCount++;
      end
      checkOutput("ho2_tristate_cycles", 32'(triCount), 32'd5);
      checkOutput("ho2_pad_out", 32'(pad_out), 32'h0A);
      checkOutput("ho2_pad_oeb", 32'(pad_oeb), 32'h00);
      checkOutput("ho2_core_in", 32'(core_in), 32'(20'h0A << 10));
      busRead("rd_status_ho2", BASE + 32'h8, 32'h0002_0001);
      busRead("rd_ctrl_ho2",   BASE + 32'h0, 32'h0000_0002);

      // Retarget during DRAIN: 2 -> 3, then 1 while draining; last write wins
      busWrite("wr_ctrl_3", BASE + 32'h0, 32'h3, 4'hF);
      busWrite("wr_ctrl_1", BASE + 32'h0, 32'h1, 4'hF);
      busRead("rd_ctrl_busy", BASE + 32'h0, 32'h8000_0001);
      repeat (10) @(posedge clk);
      busRead("rd_status_ho1", BASE + 32'h8, 32'h0001_0002);
      #1;
      checkOutput("ho1_pad_out", 32'(pad_out), 32'h0C);
      checkOutput("ho1_pad_oeb", 32'(pad_oeb), 32'h00);

      // Write back to the original sel during DRAIN: handover still completes
      busWrite("wr_ctrl_0", BASE + 32'h0, 32'h0, 4'hF);
      busWrite("wr_ctrl_1b", BASE + 32'h0, 32'h1, 4'hF);
      repeat (10) @(posedge clk);
      busRead("rd_status_back", BASE + 32'h8, 32'h0001_0003);

      // Same sel while ACTIVE: no handover
      busWrite("wr_ctrl_same", BASE + 32'h0, 32'h1, 4'hF);
      @(posedge clk);
      #1;
      checkOutput("same_pad_oeb", 32'(pad_oeb), 32'h00);
      busRead("rd_status_same", BASE + 32'h8, 32'h0001_0003);

      // Out-of-range sel is acked and ignored
      busWrite("wr_ctrl_7", BASE + 32'h0, 32'h7, 4'hF);
      busRead("rd_ctrl_7",   BASE + 32'h0, 32'h0000_0001);
      busRead("rd_status_7", BASE + 32'h8, 32'h0001_0003);

      // Byte lanes, unused register, unmapped address
      busWrite("wr_coreen_nolane", BASE + 32'h4, 32'h0, 4'hE);
      busRead("rd_coreen_nolane", BASE + 32'h4, 32'hF);
      busWrite("wr_reg_c", BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
      busRead("rd_reg_c", BASE + 32'hC, 32'h0);
      applyStimulus(BASE + 32'h10, 32'h0, 1'b0, 4'hF, rd, ok);
      checkOutput("unmapped_no_ack", 32'(ok), 32'd0);

      // Clearing the owner's enable resets it and tristates the pads
      busWrite("wr_coreen_d", BASE + 32'h4, 32'hD, 4'hF);
      checkOutput("dis_core_rst_n", 32'(core_rst_n), 32'hD);
      checkOutput("dis_pad_oeb",    32'(pad_oeb),    32'h1F);

      // Core 3 has a partial output enable
      busWrite("wr_coreen_f2", BASE + 32'h4, 32'hF, 4'hF);
      busWrite("wr_ctrl_3b",   BASE + 32'h0, 32'h3, 4'hF);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("c3_pad_oeb", 32'(pad_oeb), 32'h03);
      checkOutput("c3_pad_out", 32'(pad_out), 32'h13);
      checkOutput("c3_core_in", 32'(core_in), 32'(20'h0A << 15));
      busRead("rd_status_c3", BASE + 32'h8, 32'h0003_0004);

      // Input path latency
      @(negedge clk);
      pad_in = 5'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      pad_in = 5'h1F;
`ifdef IO_MUX_SYNC_EN
      @(posedge clk);
      #1;
      checkOutput("sync_lat1", 32'(core_in[15 +: 5]), 32'h00);
      @(posedge clk);
      #1;
      checkOutput("sync_lat2", 32'(core_in[15 +: 5]), 32'h1F);
`else
      #1;
      checkOutput("comb_lat0", 32'(core_in[15 +: 5]), 32'h1F);
`endif

      // Asynchronous reset in the middle of a DRAIN
      busWrite("wr_ctrl_0r", BASE + 32'h0, 32'h0, 4'hF);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_pad_oeb",    32'(pad_oeb),    32'h1F);
      checkOutput("arst_pad_out",    32'(pad_out),    32'h00);
      checkOutput("arst_core_in",    32'(core_in),    32'h0);
      checkOutput("arst_core_rst_n", 32'(core_rst_n), 32'h0);
      checkOutput("arst_ack",        32'(wbs_ack_o),  32'h0);
      checkOutput("arst_dat",        wbs_dat_o,       32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      busRead("rd_status_arst", BASE + 32'h8, 32'h0);
      busRead("rd_coreen_arst", BASE + 32'h4, 32'h0);
      busRead("rd_ctrl_arst",   BASE + 32'h0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
